rv_mem_arbiter: RTL

Two-requester arbiter and sequencer that shares one rv_ram32_sync instance between the PicoRV32 native memory port (requester 0) and a second bus master such as a debug/DMA unit (requester 1). It grants by round-robin, converts each granted request into the single-cycle addr_valid pulse the RAM requires, and waits for its ack. It returns a one-cycle ready pulse with read data to the granted requester, and times out with an error if the RAM never acknowledges.

---
 rtl/rv_mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between two bus masters.
// Every output is registered; each grant issues exactly one s_valid pulse.
module rv_mem_arbiter #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_valid,
    input  logic [31:0]          m0_addr,
    input  logic [31:0]          m0_wdata,
    input  logic [3:0]           m0_wstrb,
    output logic                 m0_ready,
    output logic [31:0]          m0_rdata,
    output logic                 m0_err,
    input  logic                 m1_valid,
    input  logic [31:0]          m1_addr,
    input  logic [31:0]          m1_wdata,
    input  logic [3:0]           m1_wstrb,
    output logic                 m1_ready,
    output logic [31:0]          m1_rdata,
    output logic                 m1_err,
    output logic                 s_valid,
    output logic [ADDR_BITS-1:0] s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wr_en,
    input  logic                 s_ack,
    input  logic [31:0]          s_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t               state, state_n;
    logic                 grant, grant_n;
    logic                 last_grant, last_grant_n;
    logic [7:0]           cnt, cnt_n;
    logic                 s_valid_n;
    logic [ADDR_BITS-1:0] s_addr_n;
    logic [31:0]          s_wdata_n;
    logic [3:0]           s_wr_en_n;
    logic                 m0_ready_n, m1_ready_n, m0_err_n, m1_err_n;
    logic [31:0]          m0_rdata_n, m1_rdata_n;
    logic                 pick;
    logic                 finish, finish_err;
    logic [31:0]          finish_data;

    // Only the low address bits reach the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[31:ADDR_BITS], m1_addr[31:ADDR_BITS]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            s_valid    <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wr_en    <= '0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
            s_valid    <= s_valid_n;
            s_addr     <= s_addr_n;
            s_wdata    <= s_wdata_n;
            s_wr_en    <= s_wr_en_n;
            m0_ready   <= m0_ready_n;
            m1_ready   <= m1_ready_n;
            m0_err     <= m0_err_n;
            m1_err     <= m1_err_n;
            m0_rdata   <= m0_rdata_n;
            m1_rdata   <= m1_rdata_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        s_valid_n    = 1'b0;
        s_addr_n     = s_addr;
        s_wdata_n    = s_wdata;
        s_wr_en_n    = s_wr_en;
        m0_ready_n   = 1'b0;
        m1_ready_n   = 1'b0;
        m0_err_n     = 1'b0;
        m1_err_n     = 1'b0;
        m0_rdata_n   = '0;
        m1_rdata_n   = '0;
        pick         = 1'b0;
        finish       = 1'b0;
        finish_err   = 1'b0;
        finish_data  = '0;

        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    // On a tie the requester not served last time wins.
                    pick         = !(m0_valid && (!m1_valid || last_grant));
                    grant_n      = pick;
                    last_grant_n = pick;
                    s_addr_n     = pick ? m1_addr[ADDR_BITS-1:0] : m0_addr[ADDR_BITS-1:0];
                    s_wdata_n    = pick ? m1_wdata : m0_wdata;
                    s_wr_en_n    = pick ? m1_wstrb : m0_wstrb;
                    s_valid_n    = 1'b1;
                    state_n      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (s_ack) begin
                    finish      = 1'b1;
                    finish_data = (s_wr_en == 4'b0000) ? s_rdata : 32'h0;
                end else begin
                    cnt_n = cnt + 8'd1;
                    if (cnt_n == TIMEOUT_CNT) begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end
                end
                if (finish) begin
                    state_n   = DONE;
                    s_wr_en_n = '0;
                    if (grant) begin
                        m1_ready_n = 1'b1;
                        m1_err_n   = finish_err;
                        m1_rdata_n = finish_data;
                    end else begin
                        m0_ready_n = 1'b1;
                        m0_err_n   = finish_err;
                        m0_rdata_n = finish_data;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
